parking_space_manager: RTL and testbench

Sequential occupancy controller for the eight-space lot. It sits directly downstream of the combinational exit decoder and consumes its one-hot `park_location` vector on exit requests. On entry requests it allocates the lowest free space. It runs a single gate-open sequence per served event and keeps the occupancy map, free count and full/empty flags.

---
 rtl/parking_space_manager.sv | 88 ++++++++
 tb/tb_parking_space_manager.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/parking_space_manager.sv
// parking_space_manager: eight-space occupancy controller with gate-hold sequencing
module parking_space_manager #(
    parameter int GATE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic [7:0] exit_location,
    output logic       entry_grant,
    output logic       entry_reject,
    output logic [2:0] entry_park_number,
    output logic       exit_ack,
    output logic       exit_error,
    output logic [7:0] occupancy,
    output logic [3:0] free_count,
    output logic       full,
    output logic       empty,
    output logic       gate_open
);
    typedef enum logic {IDLE, GATE} state_t;
    state_t     state;
    logic [3:0] cnt;
    logic [2:0] free_idx;
    logic       exit_valid;
    logic       serve;
    logic [7:0] occ_n;

    always_comb begin
        free_idx = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (!occupancy[i]) free_idx = 3'(i);
    end

    assign exit_valid = $onehot(exit_location) && |(exit_location & occupancy);
    assign serve      = exit_req ? exit_valid : entry_req && !full;
    assign occ_n      = exit_req ? (exit_valid ? occupancy & ~exit_location : occupancy)
                      : (entry_req && !full) ? occupancy | (8'd1 << free_idx) : occupancy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            cnt               <= 4'd0;
            occupancy         <= 8'h00;
            free_count        <= 4'd8;
            full              <= 1'b0;
            empty             <= 1'b1;
            gate_open         <= 1'b0;
            entry_grant       <= 1'b0;
            entry_reject      <= 1'b0;
            exit_ack          <= 1'b0;
            exit_error        <= 1'b0;
            entry_park_number <= 3'b000;
        end else begin
            entry_grant  <= 1'b0;
            entry_reject <= 1'b0;
            exit_ack     <= 1'b0;
            exit_error   <= 1'b0;
            if (state == GATE) begin
                if (cnt == 4'd0) begin
                    state     <= IDLE;
                    gate_open <= 1'b0;
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end else begin
                occupancy  <= occ_n;
                free_count <= 4'(8 - $countones(occ_n));
                full       <= &occ_n;
                empty      <= ~|occ_n;
                if (exit_req) begin
                    exit_ack   <= exit_valid;
                    exit_error <= !exit_valid;
                end else if (entry_req) begin
                    entry_grant  <= !full;
                    entry_reject <= full;
                    // decoder encoding is bit-reversed: pn[0] carries the index MSB
                    if (!full) entry_park_number <= {free_idx[0], free_idx[1], free_idx[2]};
                end
                if (serve) begin
                    state     <= GATE;
                    cnt       <= 4'(GATE_CYCLES - 1);
                    gate_open <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_parking_space_manager.sv
// tb_parking_space_manager: directed scoreboard bench for the parking occupancy controller
module tb_parking_space_manager;
    localparam int G = 4;

    logic       clk = 1'b0;
    logic       reset, entry_req, exit_req;
    logic [7:0] exit_location;
    logic       entry_grant, entry_reject, exit_ack, exit_error;
    logic [2:0] entry_park_number;
    logic [7:0] occupancy;
    logic [3:0] free_count;
    logic       full, empty, gate_open;

    int checks = 0, failures = 0, cyc = 0;
    logic [7:0] m_occ = 8'h00;

    typedef struct {
        logic [3:0] kind;
        logic [2:0] pn;
        logic [7:0] occ;
    } exp_t;
    exp_t q[$];

    parking_space_manager #(.GATE_CYCLES(G)) dut (
        .clk(clk), .reset(reset), .entry_req(entry_req), .exit_req(exit_req),
        .exit_location(exit_location), .entry_grant(entry_grant), .entry_reject(entry_reject),
        .entry_park_number(entry_park_number), .exit_ack(exit_ack), .exit_error(exit_error),
        .occupancy(occupancy), .free_count(free_count), .full(full), .empty(empty),
        .gate_open(gate_open)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // pulse order {grant, reject, ack, error}
    always @(negedge clk) begin
        logic [3:0] k;
        k = {entry_grant, entry_reject, exit_ack, exit_error};
        if (!reset && k != 4'b0000) begin
            if (q.size() == 0) chk("unexpected_pulse", 32'(k), 32'd0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_kind", 32'(k), 32'(e.kind));
                if (e.kind == 4'b1000) chk("park_number", 32'(entry_park_number), 32'(e.pn));
                chk("occupancy", 32'(occupancy), 32'(e.occ));
                chk("free_count", 32'(free_count), 32'(8 - $countones(e.occ)));
                chk("full", 32'(full), 32'(&e.occ));
                chk("empty", 32'(empty), 32'(~|e.occ));
                chk("gate_at_pulse", 32'(gate_open), 32'(e.kind[3] | e.kind[1]));
            end
        end
    end

    task automatic wait_pulse();
        logic got;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = entry_grant | entry_reject | exit_ack | exit_error;
        end
        chk("got_pulse", 32'(got), 32'd1);
    endtask

    task automatic count_gate(input int exp);
        int n;
        n = 0;
        while (gate_open && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("gate_cycles", 32'(n), 32'(exp));
    endtask

    task automatic push_entry(output bit served);
        exp_t e;
        int idx;
        idx = -1;
        for (int i = 7; i >= 0; i--) if (!m_occ[i]) idx = i;
        served = idx >= 0;
        if (served) begin
            m_occ[idx] = 1'b1;
            e = '{kind: 4'b1000, pn: {idx[0], idx[1], idx[2]}, occ: m_occ};
        end else e = '{kind: 4'b0100, pn: 3'd0, occ: m_occ};
        q.push_back(e);
    endtask

    task automatic push_exit(input logic [7:0] loc, output bit served);
        exp_t e;
        served = $onehot(loc) && (loc & m_occ) != 8'h00;
        if (served) m_occ = m_occ & ~loc;
        e = '{kind: served ? 4'b0010 : 4'b0001, pn: 3'd0, occ: m_occ};
        q.push_back(e);
    endtask

    task automatic do_entry();
        bit s;
        push_entry(s);
        entry_req = 1'b1;
        wait_pulse();
        entry_req = 1'b0;
        count_gate(s ? G : 0);
    endtask

    task automatic do_exit(input logic [7:0] loc);
        bit s;
        push_exit(loc, s);
        exit_location = loc;
        exit_req = 1'b1;
        wait_pulse();
        exit_req = 1'b0;
        count_gate(s ? G : 0);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_occ"}, 32'(occupancy), 32'h00);
        chk({tag, "_free"}, 32'(free_count), 32'd8);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_gate"}, 32'(gate_open), 32'd0);
        chk({tag, "_pn"}, 32'(entry_park_number), 32'd0);
        chk({tag, "_pulses"}, 32'({entry_grant, entry_reject, exit_ack, exit_error}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        bit s;
        int t0;
        reset = 1'b1;
        entry_req = 1'b0;
        exit_req = 1'b0;
        exit_location = 8'h00;
        repeat (2) @(negedge clk);
        chk_reset_values("reset");
        reset = 1'b0;
        @(negedge clk);
        chk_reset_values("after_release");

        repeat (8) do_entry();
        chk("fill_occ", 32'(occupancy), 32'hFF);
        chk("fill_full", 32'(full), 32'd1);

        do_entry();
        @(negedge clk);
        chk("reject_occ", 32'(occupancy), 32'hFF);
        chk("reject_gate", 32'(gate_open), 32'd0);

        do_exit(8'h20);
        chk("exit20_occ", 32'(occupancy), 32'hDF);
        chk("exit20_free", 32'(free_count), 32'd1);
        do_entry();

        for (int b = 2; b < 8; b++) do_exit(8'(1 << b));
        chk("pre_simul_occ", 32'(occupancy), 32'h03);

        push_exit(8'h01, s);
        push_entry(s);
        exit_location = 8'h01;
        exit_req = 1'b1;
        entry_req = 1'b1;
        wait_pulse();
        t0 = cyc;
        exit_req = 1'b0;
        chk("simul_exit_first", 32'(exit_ack), 32'd1);
        count_gate(G);
        wait_pulse();
        entry_req = 1'b0;
        chk("simul_spacing", 32'(cyc - t0), 32'(G + 1));
        count_gate(G);

        do_exit(8'h00);
        do_exit(8'h18);
        do_exit(8'h04);
        chk("invalid_occ", 32'(occupancy), 32'h03);

        push_entry(s);
        entry_req = 1'b1;
        wait_pulse();
        entry_req = 1'b0;
        chk("pre_reset_occ", 32'(occupancy), 32'h07);
        @(negedge clk);
        chk("pre_reset_gate", 32'(gate_open), 32'd1);
        #2 reset = 1'b1;
        #1 chk_reset_values("async_reset");
        m_occ = 8'h00;
        @(negedge clk);
        reset = 1'b0;
        do_entry();
        chk("post_reset_occ", 32'(occupancy), 32'h01);

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
